// File: rtl/wordcopy_pkg.sv
// Shared definitions for the wordcopy DMA: CSR map, status/mode bit positions, FSM states.
package wordcopy_pkg;

    localparam logic [3:0] CSR_CTRL   = 4'd0;
    localparam logic [3:0] CSR_DST    = 4'd1;
    localparam logic [3:0] CSR_SRC    = 4'd2;
    localparam logic [3:0] CSR_NWORDS = 4'd3;
    localparam logic [3:0] CSR_FILL   = 4'd4;
    localparam logic [3:0] CSR_MODE   = 4'd5;

    localparam int unsigned ST_BUSY_BIT   = 0;
    localparam int unsigned ST_DONE_BIT   = 1;
    localparam int unsigned MODE_FILL_BIT = 0;
    localparam int unsigned MODE_IE_BIT   = 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/wordcopy_fifo.sv
// Read-data buffer between the SDRAM read return path and the write command issue.
module wordcopy_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          wdata_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              do_push;
    logic              do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/wordcopy_dma.sv
// Avalon-MM copy/fill engine: CSR slave, control FSM, and a pipelined SDRAM master.
module wordcopy_dma
    import wordcopy_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic              slave_waitrequest,
    input  logic [3:0]        slave_address,
    input  logic              slave_read,
    output logic [31:0]       slave_readdata,
    input  logic              slave_write,
    input  logic [31:0]       slave_writedata,
    input  logic              master_waitrequest,
    output logic [31:0]       master_address,
    output logic              master_read,
    input  logic [DATA_W-1:0] master_readdata,
    input  logic              master_readdatavalid,
    output logic              master_write,
    output logic [DATA_W-1:0] master_writedata,
    output logic              done_irq
);

    localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] STEP  = 32'(DATA_W / 8);
    localparam logic [31:0] AMASK = ~(STEP - 32'd1);

    // Programmer-visible registers
    logic [31:0] dst_q, src_q, nwords_q, fill_q, rdata_q;
    logic [1:0]  mode_q;
    logic        irq_q;

    // Job engine state and its working copies
    state_e            state_q, state_d;
    logic [31:0]       d_q, d_d, s_q, s_d, n_q, n_d;
    logic              jfill_q, jfill_d;
    logic [DATA_W-1:0] jval_q, jval_d;
    logic [31:0]       rissued_q, rissued_d, wissued_q, wissued_d, wacc_q, wacc_d;
    logic [CW-1:0]     out_q, out_d;
    logic              mrd_q, mrd_d, mwr_q, mwr_d, done_q, done_d;
    logic [31:0]       maddr_q, maddr_d;
    logic [DATA_W-1:0] mwdata_q, mwdata_d;

    logic              fifo_push, fifo_pop, fifo_empty, fifo_full, issue_rd;
    logic [DATA_W-1:0] fifo_rdata;
    logic [CW-1:0]     fifo_count;
    logic              ctrl_wr, start, accept, slot_free;

    assign ctrl_wr           = slave_write && (slave_address == CSR_CTRL);
    assign start             = ctrl_wr && (state_q == S_IDLE);
    assign slave_waitrequest = ctrl_wr && (state_q != S_IDLE);
    assign accept            = (mrd_q || mwr_q) && !master_waitrequest;
    assign slot_free         = !(mrd_q || mwr_q) || accept;

    assign slave_readdata   = rdata_q;
    assign master_address   = maddr_q;
    assign master_read      = mrd_q;
    assign master_write     = mwr_q;
    assign master_writedata = mwdata_q;
    assign done_irq         = irq_q;

    wordcopy_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .wdata_i (master_readdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // CSR writes, registered CSR read data and the interrupt level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dst_q    <= '0;
            src_q    <= '0;
            nwords_q <= '0;
            fill_q   <= '0;
            mode_q   <= '0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (slave_write) begin
                unique case (slave_address)
                    CSR_DST:    dst_q    <= slave_writedata & AMASK;
                    CSR_SRC:    src_q    <= slave_writedata & AMASK;
                    CSR_NWORDS: nwords_q <= slave_writedata;
                    CSR_FILL:   fill_q   <= slave_writedata;
                    CSR_MODE:   mode_q   <= slave_writedata[1:0];
                    default:    ;
                endcase
            end
            if (slave_read) begin
                unique case (slave_address)
                    CSR_CTRL:   rdata_q <= 32'({done_q, (state_q != S_IDLE)});
                    CSR_DST:    rdata_q <= dst_q;
                    CSR_SRC:    rdata_q <= src_q;
                    CSR_NWORDS: rdata_q <= nwords_q;
                    CSR_FILL:   rdata_q <= fill_q;
                    CSR_MODE:   rdata_q <= 32'(mode_q);
                    default:    rdata_q <= '0;
                endcase
            end
            irq_q <= done_q && mode_q[MODE_IE_BIT];
        end
    end

    // Next-state: writes drain the FIFO first; reads refill it within the outstanding budget
    always_comb begin
        state_d   = state_q;
        d_d       = d_q;
        s_d       = s_q;
        n_d       = n_q;
        jfill_d   = jfill_q;
        jval_d    = jval_q;
        rissued_d = rissued_q;
        wissued_d = wissued_q;
        wacc_d    = wacc_q;
        mrd_d     = mrd_q;
        mwr_d     = mwr_q;
        maddr_d   = maddr_q;
        mwdata_d  = mwdata_q;
        done_d    = done_q;
        fifo_pop  = 1'b0;
        issue_rd  = 1'b0;
        fifo_push = master_readdatavalid && (state_q == S_RUN) && !jfill_q && !fifo_full;

        if (accept) begin
            mrd_d = 1'b0;
            mwr_d = 1'b0;
        end
        if (accept && mwr_q) begin
            wacc_d = wacc_q + 32'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    done_d    = 1'b0;
                    n_d       = nwords_q;
                    jfill_d   = mode_q[MODE_FILL_BIT];
                    jval_d    = DATA_W'(fill_q);
                    d_d       = dst_q;
                    s_d       = src_q;
                    rissued_d = '0;
                    wissued_d = '0;
                    wacc_d    = '0;
                    if (nwords_q == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        if (mode_q[MODE_FILL_BIT]) begin
                            mwr_d     = 1'b1;
                            maddr_d   = dst_q;
                            mwdata_d  = DATA_W'(fill_q);
                            d_d       = dst_q + STEP;
                            wissued_d = 32'd1;
                        end else begin
                            mrd_d     = 1'b1;
                            maddr_d   = src_q;
                            s_d       = src_q + STEP;
                            rissued_d = 32'd1;
                            issue_rd  = 1'b1;
                        end
                    end
                end
            end
            S_RUN: begin
                if (accept && mwr_q && (wacc_q == n_q - 32'd1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (slot_free) begin
                    if (jfill_q) begin
                        if (wissued_q < n_q) begin
                            mwr_d     = 1'b1;
                            maddr_d   = d_q;
                            mwdata_d  = jval_q;
                            d_d       = d_q + STEP;
                            wissued_d = wissued_q + 32'd1;
                        end
                    end else if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        mwr_d     = 1'b1;
                        maddr_d   = d_q;
                        mwdata_d  = fifo_rdata;
                        d_d       = d_q + STEP;
                        wissued_d = wissued_q + 32'd1;
                    end else if ((rissued_q < n_q) &&
                                 (({1'b0, out_q} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH))) begin
                        mrd_d     = 1'b1;
                        maddr_d   = s_q;
                        s_d       = s_q + STEP;
                        rissued_d = rissued_q + 32'd1;
                        issue_rd  = 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        out_d = out_q + CW'(issue_rd) - CW'(fifo_push);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            d_q       <= '0;
            s_q       <= '0;
            n_q       <= '0;
            jfill_q   <= 1'b0;
            jval_q    <= '0;
            rissued_q <= '0;
            wissued_q <= '0;
            wacc_q    <= '0;
            out_q     <= '0;
            mrd_q     <= 1'b0;
            mwr_q     <= 1'b0;
            maddr_q   <= '0;
            mwdata_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            d_q       <= d_d;
            s_q       <= s_d;
            n_q       <= n_d;
            jfill_q   <= jfill_d;
            jval_q    <= jval_d;
            rissued_q <= rissued_d;
            wissued_q <= wissued_d;
            wacc_q    <= wacc_d;
            out_q     <= out_d;
            mrd_q     <= mrd_d;
            mwr_q     <= mwr_d;
            maddr_q   <= maddr_d;
            mwdata_q  <= mwdata_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_wordcopy_dma.sv
// Directed bench for wordcopy_dma with an SDRAM model of configurable latency and random stalls.
module tb_wordcopy_dma;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        slave_waitrequest;
    logic [3:0]  slave_address = '0;
    logic        slave_read = 1'b0;
    logic [31:0] slave_readdata;
    logic        slave_write = 1'b0;
    logic [31:0] slave_writedata = '0;
    logic        master_waitrequest = 1'b0;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata = '0;
    logic        master_readdatavalid = 1'b0;
    logic        master_write;
    logic [31:0] master_writedata;
    logic        done_irq;

    always #5 clk = ~clk;

    wordcopy_dma u_dut (
        .clk                  (clk),
        .rst                  (rst),
        .slave_waitrequest    (slave_waitrequest),
        .slave_address        (slave_address),
        .slave_read           (slave_read),
        .slave_readdata       (slave_readdata),
        .slave_write          (slave_write),
        .slave_writedata      (slave_writedata),
        .master_waitrequest   (master_waitrequest),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .master_write         (master_write),
        .master_writedata     (master_writedata),
        .done_irq             (done_irq)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // SDRAM model: decides stalls on the falling edge, returns reads in order after lat cycles
    logic [31:0] mem [16384];
    logic [31:0] q_addr [$];
    int          q_due [$];
    logic [31:0] wlog_addr [$];
    logic [31:0] wlog_data [$];
    int          wlog_cyc [$];
    int          cyc = 0, lat = 1, rd_cnt = 0, wr_cnt = 0, both_cnt = 0, strobe_cnt = 0;
    int          max_inflight = 0, infl;
    bit          rand_wait = 1'b0, wreq;
    logic [31:0] ra;

    always @(negedge clk) begin
        cyc++;
        if (master_read && master_write) both_cnt++;
        if (master_read || master_write) strobe_cnt++;
        infl = (rd_cnt + int'(master_read)) - (wr_cnt + int'(master_write));
        if (infl > max_inflight) max_inflight = infl;
        wreq = rand_wait && ($urandom_range(0, 2) == 0);
        if (master_read && !wreq) begin
            q_addr.push_back(master_address);
            q_due.push_back(cyc + lat);
            rd_cnt++;
        end
        if (master_write && !wreq) begin
            mem[master_address[15:2]] = master_writedata;
            wlog_addr.push_back(master_address);
            wlog_data.push_back(master_writedata);
            wlog_cyc.push_back(cyc);
            wr_cnt++;
        end
        master_waitrequest = wreq;
        if (q_due.size() != 0 && q_due[0] <= cyc) begin
            ra = q_addr.pop_front();
            void'(q_due.pop_front());
            master_readdatavalid = 1'b1;
            master_readdata      = mem[ra[15:2]];
        end else begin
            master_readdatavalid = 1'b0;
            master_readdata      = '0;
        end
    end

    task automatic reset_stats();
        rd_cnt = 0; wr_cnt = 0; both_cnt = 0; strobe_cnt = 0; max_inflight = 0;
        wlog_addr.delete(); wlog_data.delete(); wlog_cyc.delete();
    endtask

    task automatic csr_write(input logic [3:0] a, input logic [31:0] v, output int stall);
        bit acc = 1'b0;
        stall = 0;
        @(negedge clk);
        slave_address = a; slave_writedata = v; slave_write = 1'b1;
        for (int i = 0; i < 2000 && !acc; i++) begin
            #1;
            if (slave_waitrequest) begin
                stall++;
                @(negedge clk);
            end else begin
                @(posedge clk);
                acc = 1'b1;
            end
        end
        check("csr_write_accepted", 32'(acc), 32'd1);
        @(negedge clk);
        slave_write = 1'b0;
    endtask

    task automatic csr_read(input logic [3:0] a, output logic [31:0] v);
        @(negedge clk);
        slave_address = a; slave_read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        slave_read = 1'b0;
        v = slave_readdata;
    endtask

    task automatic wait_idle(input string tag, output logic [31:0] st);
        bit fin = 1'b0;
        st = '0;
        for (int i = 0; i < 2000 && !fin; i++) begin
            csr_read(4'd0, st);
            if (!st[0]) fin = 1'b1;
        end
        check({tag, "_finished"}, 32'(fin), 32'd1);
    endtask

    function automatic logic [31:0] src_a(input int i);
        return 32'hA000_0000 + 32'(i);
    endfunction

    function automatic logic [31:0] src_b(input int i);
        return 32'h5A00_0000 + 32'(i) * 32'h0001_0203;
    endfunction

    int          stall;
    logic [31:0] st, rv;

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = '0;
        for (int i = 0; i < 4; i++)  mem[(32'h1000 >> 2) + i] = src_a(i);
        for (int i = 0; i < 20; i++) mem[(32'h4000 >> 2) + i] = src_b(i);

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check("rst_maddr", master_address, 32'h0);
        check("rst_mread", 32'(master_read), 32'h0);
        check("rst_mwrite", 32'(master_write), 32'h0);
        check("rst_mwdata", master_writedata, 32'h0);
        check("rst_sreaddata", slave_readdata, 32'h0);
        check("rst_irq", 32'(done_irq), 32'h0);
        check("rst_swait", 32'(slave_waitrequest), 32'h0);
        csr_read(4'd0, st);
        check("rst_status", st, 32'h0);

        // Copy 4 words, zero wait, latency 1
        lat = 1; rand_wait = 1'b0;
        csr_write(4'd2, 32'h1000, stall);
        csr_write(4'd1, 32'h2000, stall);
        csr_write(4'd3, 32'd4, stall);
        csr_write(4'd5, 32'd0, stall);
        reset_stats();
        csr_write(4'd0, 32'd1, stall);
        check("t1_first_read_strobe", 32'(master_read), 32'd1);
        check("t1_first_read_addr", master_address, 32'h1000);
        wait_idle("t1", st);
        check("t1_status", st, 32'h2);
        check("t1_reads", 32'(rd_cnt), 32'd4);
        check("t1_writes", 32'(wr_cnt), 32'd4);
        for (int i = 0; i < 4 && i < wlog_addr.size(); i++) begin
            check($sformatf("t1_waddr%0d", i), wlog_addr[i], 32'h2000 + 32'(4 * i));
            check($sformatf("t1_wdata%0d", i), wlog_data[i], src_a(i));
        end
        check("t1_irq_ie_off", 32'(done_irq), 32'd0);

        // Fill 3 words
        csr_write(4'd5, 32'd1, stall);
        csr_write(4'd4, 32'h99AB_CDEF, stall);
        csr_write(4'd1, 32'h89C0, stall);
        csr_write(4'd3, 32'd3, stall);
        reset_stats();
        csr_write(4'd0, 32'd1, stall);
        check("t2_first_write_strobe", 32'(master_write), 32'd1);
        check("t2_first_write_addr", master_address, 32'h89C0);
        check("t2_first_write_data", master_writedata, 32'h99AB_CDEF);
        wait_idle("t2", st);
        check("t2_status", st, 32'h2);
        check("t2_reads", 32'(rd_cnt), 32'd0);
        check("t2_writes", 32'(wr_cnt), 32'd3);
        for (int i = 0; i < 3 && i < wlog_addr.size(); i++) begin
            check($sformatf("t2_waddr%0d", i), wlog_addr[i], 32'h89C0 + 32'(4 * i));
            check($sformatf("t2_wdata%0d", i), wlog_data[i], 32'h99AB_CDEF);
        end
        if (wlog_cyc.size() == 3) check("t2_one_per_cycle", 32'(wlog_cyc[2] - wlog_cyc[0]), 32'd2);
        else check("t2_log_size", 32'(wlog_cyc.size()), 32'd3);

        // Copy 20 words, latency 6, random stalls; unaligned DST must be forced aligned
        lat = 6; rand_wait = 1'b1;
        csr_write(4'd5, 32'd0, stall);
        csr_write(4'd2, 32'h4000, stall);
        csr_write(4'd1, 32'h6003, stall);
        csr_write(4'd3, 32'd20, stall);
        csr_read(4'd1, rv);
        check("t3_dst_aligned", rv, 32'h6000);
        reset_stats();
        csr_write(4'd0, 32'd1, stall);
        wait_idle("t3", st);
        check("t3_status", st, 32'h2);
        check("t3_reads", 32'(rd_cnt), 32'd20);
        check("t3_writes", 32'(wr_cnt), 32'd20);
        for (int i = 0; i < 20 && i < wlog_addr.size(); i++) begin
            check($sformatf("t3_waddr%0d", i), wlog_addr[i], 32'h6000 + 32'(4 * i));
            check($sformatf("t3_wdata%0d", i), wlog_data[i], src_b(i));
        end
        check("t3_rd_wr_overlap", 32'(both_cnt), 32'd0);
        check("t3_inflight_over8", 32'(max_inflight > 8), 32'd0);

        // Zero-length job with IE set
        lat = 1; rand_wait = 1'b0;
        csr_write(4'd5, 32'd2, stall);
        csr_write(4'd3, 32'd0, stall);
        reset_stats();
        csr_write(4'd0, 32'd1, stall);
        csr_read(4'd0, st);
        check("t4_status_done", st, 32'h2);
        check("t4_irq", 32'(done_irq), 32'd1);
        check("t4_no_strobes", 32'(strobe_cnt), 32'd0);

        // Start while busy stalls; register writes while busy do not disturb the running job
        lat = 6;
        csr_write(4'd5, 32'd0, stall);
        csr_write(4'd2, 32'h1000, stall);
        csr_write(4'd1, 32'h3000, stall);
        csr_write(4'd3, 32'd4, stall);
        reset_stats();
        csr_write(4'd0, 32'd1, stall);
        check("t5_start_no_stall", 32'(stall), 32'd0);
        csr_write(4'd3, 32'd2, stall);
        check("t5_busy_reg_no_stall", 32'(stall), 32'd0);
        csr_write(4'd1, 32'h3800, stall);
        csr_write(4'd0, 32'd1, stall);
        check("t5_ctrl_stalled", 32'(stall > 0), 32'd1);
        check("t5_job1_done_at_accept", 32'(wr_cnt), 32'd4);
        wait_idle("t5", st);
        check("t5_writes", 32'(wr_cnt), 32'd6);
        for (int i = 0; i < 6 && i < wlog_addr.size(); i++) begin
            check($sformatf("t5_waddr%0d", i), wlog_addr[i],
                  (i < 4) ? 32'h3000 + 32'(4 * i) : 32'h3800 + 32'(4 * (i - 4)));
            check($sformatf("t5_wdata%0d", i), wlog_data[i], src_a((i < 4) ? i : i - 4));
        end

        // Reset in the middle of a 12-word copy
        csr_write(4'd5, 32'd2, stall);
        csr_write(4'd2, 32'h4000, stall);
        csr_write(4'd1, 32'h7000, stall);
        csr_write(4'd3, 32'd12, stall);
        reset_stats();
        csr_write(4'd0, 32'd1, stall);
        for (int i = 0; i < 500 && wr_cnt < 5; i++) begin
            @(posedge clk);
            #2;
        end
        check("t6_words_before_rst", 32'(wr_cnt), 32'd5);
        rst = 1'b1;
        #1;
        check("t6_rst_mread", 32'(master_read), 32'd0);
        check("t6_rst_mwrite", 32'(master_write), 32'd0);
        check("t6_rst_maddr", master_address, 32'h0);
        check("t6_rst_mwdata", master_writedata, 32'h0);
        check("t6_rst_sreaddata", slave_readdata, 32'h0);
        check("t6_rst_irq", 32'(done_irq), 32'd0);
        check("t6_late_rdv_pending", 32'(q_addr.size() > 0), 32'd1);
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (12) @(negedge clk);
        check("t6_late_rdv_drained", 32'(q_addr.size()), 32'd0);
        csr_read(4'd0, st);
        check("t6_status_after_rst", st, 32'h0);
        csr_write(4'd2, 32'h4000, stall);
        csr_write(4'd1, 32'h7800, stall);
        csr_write(4'd3, 32'd3, stall);
        reset_stats();
        csr_write(4'd0, 32'd1, stall);
        wait_idle("t6", st);
        check("t6_writes", 32'(wr_cnt), 32'd3);
        for (int i = 0; i < 3 && i < wlog_addr.size(); i++) begin
            check($sformatf("t6_waddr%0d", i), wlog_addr[i], 32'h7800 + 32'(4 * i));
            check($sformatf("t6_wdata%0d", i), wlog_data[i], src_b(i));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
